// File: rtl/ifu_fetch_stage.sv
// IFU fetch stage: fetch PC, credit-limited imem requests, in-order response buffer,
// decode handshake and branch redirect. Optional perf counters under IFU_PERF_CNT_EN.
module ifu_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
);
  localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW         = PW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] PC0        = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [31:0]   buf_mem [DEPTH];

  logic [31:0]   redirect_base;
  logic          unused_redirect_lsbs;
  logic          drop_active;
  logic          req_fire;
  logic          pop;
  logic          push;

  assign redirect_base        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign drop_active          = (drop_cnt_q != '0);

  // Credit counts both outstanding requests and buffered words, so the buffer can never overflow.
  assign imem_req_valid = !reset && !redirect_valid &&
                          (({1'b0, inflight_q} + {1'b0, count_q}) < CREDIT_MAX);
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid = (count_q != '0);
  assign if_instr = if_valid ? buf_mem[head_q] : NOP;
  assign if_pc    = out_pc_q;

  assign pop  = if_valid && if_ready && !redirect_valid;
  assign push = imem_rsp_valid && !redirect_valid && !drop_active;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_pc_d   = out_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      // Everything still outstanding after this cycle's response belongs to the old path.
      fetch_pc_d = redirect_base;
      out_pc_d   = redirect_base;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      drop_cnt_d = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        out_pc_d = out_pc_q + 32'd4;
        head_d   = head_q + PW'(1);
      end
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      if (imem_rsp_valid && drop_active) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= PC0;
      out_pc_q   <= PC0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[tail_q] <= imem_rsp_data;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_dropped_d = perf_dropped_q + 32'(imem_rsp_valid && (redirect_valid || drop_active));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  assign perf_fetched = '0;
  assign perf_dropped = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed testbench for ifu_fetch_stage: vector table for streaming/stall, plus
// hand-written redirect and reset sequences against a latency-configurable memory model.
module tb_ifu_fetch_stage;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;

  ifu_fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory model: in-order responses, lat cycles after acceptance.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];
  int    lat        = 1;
  int    cyc        = 0;
  int    req_hs     = 0;
  int    tb_pops    = 0;
  int    acc_since  = 0;
  int    pops_since = 0;
  int    occ_max    = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      pend.delete();
      req_hs     <= 0;
      tb_pops    <= 0;
      acc_since  <= 0;
      pops_since <= 0;
    end else begin
      if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) pend.push_back('{addr: imem_addr, due: cyc + lat});
      req_hs <= req_hs + ((imem_req_valid && imem_req_ready) ? 1 : 0);
      if (if_valid && if_ready && !redirect_valid) begin
        tb_pops <= tb_pops + 1;
        $display("pop pc=%h instr=%h", if_pc, if_instr);
      end
      if (redirect_valid) begin
        acc_since  <= 0;
        pops_since <= 0;
      end else begin
        acc_since  <= acc_since + ((imem_req_valid && imem_req_ready) ? 1 : 0);
        pops_since <= pops_since + ((if_valid && if_ready) ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid <= 1'b1;
      imem_rsp_data  <= mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end
    if (acc_since - pops_since > occ_max) occ_max <= acc_since - pops_since;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  initial begin
    // 1-cycle memory streaming, then a short decode stall that exhausts credit.
    vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[6]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    vecs[7]  = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    vecs[8]  = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
    vecs[9]  = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};
    vecs[10] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h20};
    vecs[11] = '{1'b0, 1'b1, 32'h2C, 1'b1, 32'h20};
    vecs[12] = '{1'b1, 1'b0, 32'h30, 1'b1, 32'h20};
    vecs[13] = '{1'b1, 1'b1, 32'h30, 1'b1, 32'h24};
    vecs[14] = '{1'b1, 1'b1, 32'h34, 1'b1, 32'h28};

    reset          = 1'b1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    lat            = 1;

    // Reset state with stimulus pending
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_dropped", perf_dropped, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) @(negedge clk);
      if_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_if_instr", i), if_instr,
          vecs[i].exp_vld ? mem_word(vecs[i].exp_pc) : NOP);
    end

    // Decode stalled for 10 cycles: credit caps requests, output holds, then drains in order
    if_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c >= 2) begin
        chk($sformatf("stall%0d_if_pc", c), if_pc, 32'h0);
        chk($sformatf("stall%0d_if_instr", c), if_instr, mem_word(32'h0));
      end
    end
    chk("stall_req_count", 32'(req_hs), 32'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if_ready = 1'b1;
      #1;
      chk($sformatf("drain%0d_if_valid", k), 32'(if_valid), 32'd1);
      chk($sformatf("drain%0d_if_pc", k), if_pc, 32'(4 * k));
      chk($sformatf("drain%0d_if_instr", k), if_instr, mem_word(32'(4 * k)));
    end

    // 3-cycle memory, 3 requests in flight, redirect to 0x100 as the first returns
    lat            = 3;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    redirect_pc    = 32'h100;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      imem_req_ready = (c != 3);
      redirect_valid = (c == 3);
      #1;
      if (c == 3) chk("rd1_req_blocked", 32'(imem_req_valid), 32'd0);
      if (c == 4) begin
        chk("rd1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd1_addr", imem_addr, 32'h100);
      end
      if (c >= 4 && c <= 7) chk($sformatf("rd1_c%0d_if_valid", c), 32'(if_valid), 32'd0);
      if (c == 8) begin
        chk("rd1_if_valid", 32'(if_valid), 32'd1);
        chk("rd1_if_pc", if_pc, 32'h100);
        chk("rd1_if_instr", if_instr, mem_word(32'h100));
        chk("rd1_perf_dropped", perf_dropped, PERF ? 32'd3 : 32'd0);
        chk("rd1_perf_fetched", perf_fetched, PERF ? 32'd0 : 32'd0);
      end
    end
    redirect_valid = 1'b0;

    // Unaligned redirect colliding with a response and a pop
    lat            = 1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_pc    = 32'h203;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      redirect_valid = (c == 5);
      #1;
      if (c == 5) begin
        chk("rd2_pop_attempt_valid", 32'(if_valid), 32'd1);
        chk("rd2_pop_attempt_pc", if_pc, 32'h0C);
        chk("rd2_rsp_present", 32'(imem_rsp_valid), 32'd1);
        chk("rd2_req_blocked", 32'(imem_req_valid), 32'd0);
      end
      if (c == 6) begin
        chk("rd2_addr", imem_addr, 32'h200);
        chk("rd2_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd2_if_valid", 32'(if_valid), 32'd0);
        chk("rd2_perf_fetched", perf_fetched, PERF ? 32'd3 : 32'd0);
        chk("rd2_perf_dropped", perf_dropped, PERF ? 32'd1 : 32'd0);
        chk("rd2_tb_pops", 32'(tb_pops), 32'd3);
      end
      if (c == 7) chk("rd2_c7_if_valid", 32'(if_valid), 32'd0);
      if (c == 8) begin
        chk("rd2_new_if_valid", 32'(if_valid), 32'd1);
        chk("rd2_new_if_pc", if_pc, 32'h200);
        chk("rd2_new_if_instr", if_instr, mem_word(32'h200));
      end
    end
    redirect_valid = 1'b0;

    // Asynchronous reset with two words buffered
    lat      = 1;
    if_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("ares_pre_if_valid", 32'(if_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ares_if_valid", 32'(if_valid), 32'd0);
    chk("ares_req_valid", 32'(imem_req_valid), 32'd0);
    chk("ares_if_instr", if_instr, NOP);
    chk("ares_if_pc", if_pc, 32'h0);
    chk("ares_perf_fetched", perf_fetched, 32'h0);
    chk("ares_perf_dropped", perf_dropped, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ares_restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("ares_restart_addr", imem_addr, 32'h0);
    chk("ares_restart_if_valid", 32'(if_valid), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("ares_first_if_valid", 32'(if_valid), 32'd1);
    chk("ares_first_if_pc", if_pc, 32'h0);
    chk("ares_first_if_instr", if_instr, mem_word(32'h0));

    // Buffered plus in-flight words never exceeded the buffer depth
    n_cmp++;
    if (occ_max > DEPTH) begin
      n_err++;
      $display("FAIL occupancy_bound: got %0d, expected at most %0d", occ_max, DEPTH);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1);
  end

endmodule
